median_filter_stream: RTL and testbench

Parametrised streaming 1-D median filter. It is the successor to the push-button/memory-driven median filter: a continuous sample stream with valid/ready handshaking replaces the fixed 3-tap, button-stepped datapath. Window size, data width and edge-padding mode are generic, and frames are delimited by a last flag. It sits between the sample memory/reader and the display/output formatter.

---
 rtl/median_pkg.sv | 16 +
 rtl/median_select.sv | 33 +++
 rtl/median_filter_stream.sv | 125 ++++++++++++
 tb/tb_median_filter_stream.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants for the streaming median filter family: edge modes,
// FSM state encoding and window-size legality check.
package median_pkg;

    localparam int unsigned EDGE_ZERO = 0;
    localparam int unsigned EDGE_REPL = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    function automatic bit win_legal(input int unsigned w);
        return (w >= 3) && (w <= 9) && ((w % 2) == 1);
    endfunction

endpackage

// File: rtl/median_select.sv
// Combinational rank selector: returns the median of WIN unsigned taps.
// Ties are broken by tap index so exactly one tap matches rank WIN/2.
module median_select #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WIN    = 3
) (
    input  logic [WIN*DATA_W-1:0] taps,
    output logic [DATA_W-1:0]     median
);

    localparam int unsigned H  = WIN / 2;
    localparam int unsigned RW = $clog2(WIN + 1);

    logic [RW-1:0] rank;

    always_comb begin
        median = '0;
        rank   = '0;
        for (int j = 0; j < WIN; j++) begin
            rank = '0;
            for (int k = 0; k < WIN; k++) begin
                if (k != j) begin
                    if ((taps[k*DATA_W +: DATA_W] < taps[j*DATA_W +: DATA_W]) ||
                        ((k < j) && (taps[k*DATA_W +: DATA_W] == taps[j*DATA_W +: DATA_W])))
                        rank = rank + RW'(1);
                end
            end
            if (rank == RW'(H))
                median = taps[j*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/median_filter_stream.sv
// Streaming 1-D median filter with valid/ready handshake, frame edge padding
// and a two-stage pipeline (window shift register, output register).
module median_filter_stream
    import median_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WIN       = 3,
    parameter int unsigned EDGE_MODE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned H  = WIN / 2;
    localparam int unsigned CW = $clog2(WIN + 1);

    if (!win_legal(WIN)) begin : g_bad_win
        $error("median_filter_stream: WIN must be odd and within 3..9");
    end

    logic [1:0]            state, state_next;
    logic                  live;
    logic [WIN*DATA_W-1:0] taps;
    logic                  s1_valid, s1_last;
    logic [CW-1:0]         fill, flush_cnt;
    logic [DATA_W-1:0]     last_sample, median, edge_pad, flush_pad, shift_in;
    logic                  s2_free, s1_adv, accept, flush_shift, shift, s2_load, produce;

    assign s2_free     = !out_valid || out_ready;
    assign s1_adv      = !s1_valid || s2_free;
    assign in_ready    = live && ((state == ST_IDLE) || (state == ST_RUN)) && s1_adv;
    assign accept      = in_valid && in_ready;
    assign flush_shift = (state == ST_FLUSH) && s1_adv && (flush_cnt != CW'(H));
    assign shift       = accept || flush_shift;
    assign s2_load     = s1_valid && s2_free;
    // The shift about to happen completes a window once fill reaches H+1.
    assign produce     = (state != ST_IDLE) && (fill >= CW'(H));
    assign edge_pad    = (EDGE_MODE == EDGE_REPL) ? in_data : '0;
    assign flush_pad   = (EDGE_MODE == EDGE_REPL) ? last_sample : '0;
    assign shift_in    = accept ? in_data : flush_pad;

    median_select #(.DATA_W(DATA_W), .WIN(WIN)) u_select (
        .taps   (taps),
        .median (median)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = in_last ? ST_FLUSH : ST_RUN;
            ST_RUN:   if (accept && in_last) state_next = ST_FLUSH;
            ST_FLUSH: if (s2_load && s1_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // S1: window, fill/flush bookkeeping and handshake gating.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            live        <= 1'b0;
            busy        <= 1'b0;
            taps        <= '0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            fill        <= '0;
            flush_cnt   <= '0;
            last_sample <= '0;
        end else begin
            live <= 1'b1;
            busy <= (state_next != ST_IDLE);
            if (shift) begin
                if (state == ST_IDLE) begin
                    taps <= {in_data, {(WIN-1){edge_pad}}};
                    fill <= CW'(1);
                end else begin
                    taps <= {shift_in, taps[WIN*DATA_W-1:DATA_W]};
                    if (fill != CW'(H + 1))
                        fill <= fill + CW'(1);
                end
                s1_valid <= produce;
                s1_last  <= flush_shift && (flush_cnt == CW'(H - 1));
                if (flush_shift)
                    flush_cnt <= flush_cnt + CW'(1);
                if (accept && in_last)
                    last_sample <= in_data;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if ((state == ST_FLUSH) && (state_next == ST_IDLE)) begin
                fill      <= '0;
                flush_cnt <= '0;
            end
        end
    end

    // S2: output register, held while the consumer stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= median;
                out_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_median_filter_stream.sv
// Directed bench for median_filter_stream: four parameter variants driven
// from shared stimulus, expected medians worked out by hand.
module tb_median_filter_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid, in_ready, out_valid, out_last, busy;
    logic [7:0] in_data;
    logic       in_last, out_ready;
    logic [7:0] out_data [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // 0: WIN3 replicate, 1: WIN3 zero, 2: WIN5 replicate, 3: WIN5 zero
    median_filter_stream #(.DATA_W(8), .WIN(3), .EDGE_MODE(1)) u_w3r (
        .clock(clk), .reset(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0]));
    median_filter_stream #(.DATA_W(8), .WIN(3), .EDGE_MODE(0)) u_w3z (
        .clock(clk), .reset(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1]));
    median_filter_stream #(.DATA_W(8), .WIN(5), .EDGE_MODE(1)) u_w5r (
        .clock(clk), .reset(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_data(out_data[2]), .out_last(out_last[2]), .busy(busy[2]));
    median_filter_stream #(.DATA_W(8), .WIN(5), .EDGE_MODE(0)) u_w5z (
        .clock(clk), .reset(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid[3]), .out_ready(out_ready),
        .out_data(out_data[3]), .out_last(out_last[3]), .busy(busy[3]));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic check_idle_outputs(input int inst, input string tag);
        check($sformatf("%s_out_valid%0d", tag, inst), int'(out_valid[inst]), 0);
        check($sformatf("%s_out_data%0d", tag, inst), int'(out_data[inst]), 0);
        check($sformatf("%s_out_last%0d", tag, inst), int'(out_last[inst]), 0);
        check($sformatf("%s_in_ready%0d", tag, inst), int'(in_ready[inst]), 0);
        check($sformatf("%s_busy%0d", tag, inst), int'(busy[inst]), 0);
    endtask

    // Streams one frame into instance inst, holding out_ready low for the
    // first hold cycles, and checks every result and its last flag in order.
    task automatic run_frame(input int inst, input logic [7:0] xs[$],
                             input logic [7:0] ys[$], input int hold, input string tag);
        int   si  = 0;
        int   ri  = 0;
        int   cyc = 0;
        logic acc;
        while (ri < ys.size() && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc >= hold);
            in_valid  = '0;
            in_last   = 1'b0;
            if (si < xs.size()) begin
                in_valid[inst] = 1'b1;
                in_data        = xs[si];
                in_last        = (si == xs.size() - 1);
            end
            #1;
            acc = in_valid[inst] && in_ready[inst];
            if (hold > 0 && (cyc == hold / 2 || cyc == hold - 1)) begin
                check($sformatf("%s_stall_in_ready_c%0d", tag, cyc), int'(in_ready[inst]), 0);
                check($sformatf("%s_stall_out_valid_c%0d", tag, cyc), int'(out_valid[inst]), 1);
                check($sformatf("%s_stall_out_data_c%0d", tag, cyc), int'(out_data[inst]), int'(ys[0]));
            end
            if (out_valid[inst] && out_ready) begin
                check($sformatf("%s_data%0d", tag, ri), int'(out_data[inst]), int'(ys[ri]));
                check($sformatf("%s_last%0d", tag, ri), int'(out_last[inst]),
                      (ri == ys.size() - 1) ? 1 : 0);
                ri++;
            end
            @(posedge clk);
            if (acc) si++;
            cyc++;
        end
        check($sformatf("%s_result_count", tag), ri, ys.size());
        in_valid  = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check($sformatf("%s_accepted", tag), si, xs.size());
        check($sformatf("%s_no_extra", tag), int'(out_valid[inst]), 0);
        check($sformatf("%s_busy_end", tag), int'(busy[inst]), 0);
    endtask

    initial begin
        int sent;
        int cyc;
        logic acc;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check_idle_outputs(i, "reset");

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_first_edge", int'(in_ready[0]), 0);
        @(posedge clk);
        #1;
        check("in_ready_after_first_edge", int'(in_ready[0]), 1);

        run_frame(0, '{8'd5, 8'd1, 8'd9, 8'd3}, '{8'd5, 8'd5, 8'd3, 8'd3}, 0, "w3_repl");
        run_frame(1, '{8'd5, 8'd1, 8'd9, 8'd3}, '{8'd1, 8'd5, 8'd3, 8'd3}, 0, "w3_zero");
        run_frame(2, '{8'd10, 8'd10, 8'd200, 8'd10, 8'd10},
                     '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 0, "w5_impulse");
        run_frame(3, '{8'd7}, '{8'd0}, 0, "w5_zero_single");
        run_frame(2, '{8'd7}, '{8'd7}, 0, "w5_repl_single");
        run_frame(0, '{8'd3, 8'd7, 8'd2, 8'd8, 8'd1, 8'd9, 8'd4, 8'd6},
                     '{8'd3, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6, 8'd6}, 12, "w3_backpressure");

        // Partial frame, then reset in the middle of it.
        sent = 0;
        cyc  = 0;
        while (sent < 3 && cyc < 50) begin
            @(negedge clk);
            in_valid    = '0;
            in_valid[0] = 1'b1;
            in_data     = 8'(20 + 10 * sent);
            in_last     = 1'b0;
            #1;
            acc = in_ready[0];
            @(posedge clk);
            if (acc) sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = '0;
        check("midframe_sent", sent, 3);
        check("midframe_busy", int'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0, "midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, '{8'd4, 8'd4, 8'd4}, '{8'd4, 8'd4, 8'd4}, 0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
